// File: rtl/usb_power_ctrl.sv
// usb_power_ctrl: per-port SMARC USB_EN_OC# merger with inrush blanking,
// debounced over-current detection, optional auto-retry and sticky status.
module usb_power_ctrl #(
    parameter int NUM_PORTS       = 2,
    parameter int BLANK_CYCLES    = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RETRY_CYCLES    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] enable,
    input  logic [NUM_PORTS-1:0] usb_en_oc_n_in,
    output logic [NUM_PORTS-1:0] usb_en_oc_n_oe,
    input  logic [NUM_PORTS-1:0] usb_drvvbus,
    output logic [NUM_PORTS-1:0] usb_pwrfault,
    input  logic [NUM_PORTS-1:0] fault_clr,
    output logic [NUM_PORTS-1:0] fault_sticky
);

    localparam int M1 = (BLANK_CYCLES > DEBOUNCE_CYCLES)
                      ? BLANK_CYCLES : DEBOUNCE_CYCLES;
    localparam int MAXC = (M1 > RETRY_CYCLES) ? M1 : RETRY_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    localparam logic [CW-1:0] BLANK_LAST =
        CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CW-1:0] DEB_LAST =
        CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
    localparam logic [CW-1:0] RETRY_LAST =
        CW'((RETRY_CYCLES > 0) ? RETRY_CYCLES - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_BLANK,
        ST_ON,
        ST_FAULT
    } state_t;

    genvar p;
    for (p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [1:0]    oc_sync;
        logic [1:0]    vb_sync;
        logic          oc;
        logic          vbus;
        state_t        state;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_inc;
        logic          pwr_q;
        logic          sticky_q;

        // Two-flop synchronisers for the pin level and the VBUS request
        always_ff @(posedge clk) begin
            if (rst) begin
                oc_sync <= 2'b11;
                vb_sync <= 2'b00;
            end else begin
                oc_sync <= {oc_sync[0], usb_en_oc_n_in[p]};
                vb_sync <= {vb_sync[0], usb_drvvbus[p]};
            end
        end

        assign oc      = ~oc_sync[1];
        assign vbus    = vb_sync[1];
        assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

        // Power state machine; pwrfault tracks the next state so it is
        // high exactly while the registered state is FAULT
        always_ff @(posedge clk) begin
            if (rst) begin
                state    <= ST_OFF;
                cnt      <= '0;
                pwr_q    <= 1'b0;
                sticky_q <= 1'b0;
            end else begin
                pwr_q <= 1'b0;
                if (fault_clr[p]) begin
                    sticky_q <= 1'b0;
                end
                if (!enable[p] || !vbus) begin
                    state <= ST_OFF;
                    cnt   <= '0;
                end else begin
                    unique case (state)
                        ST_OFF: begin
                            cnt   <= '0;
                            state <= (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;
                        end
                        ST_BLANK: begin
                            if (cnt == BLANK_LAST) begin
                                state <= ST_ON;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                        ST_ON: begin
                            if (!oc) begin
                                cnt <= '0;
                            end else if (cnt == DEB_LAST) begin
                                state    <= ST_FAULT;
                                cnt      <= '0;
                                pwr_q    <= 1'b1;
                                sticky_q <= 1'b1;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                        ST_FAULT: begin
                            if (RETRY_CYCLES != 0 && cnt == RETRY_LAST) begin
                                state <= (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;
                                cnt   <= '0;
                            end else begin
                                pwr_q <= 1'b1;
                                cnt   <= (RETRY_CYCLES == 0) ? cnt : cnt_inc;
                            end
                        end
                        default: begin
                            state <= ST_OFF;
                            cnt   <= '0;
                        end
                    endcase
                end
            end
        end

        assign usb_en_oc_n_oe[p] = enable[p]
                                 & (state == ST_OFF || state == ST_FAULT);
        assign usb_pwrfault[p]   = pwr_q;
        assign fault_sticky[p]   = sticky_q;
    end

endmodule
